// File: rtl/serv_immdec_wide.sv
// serv_immdec_wide: captures an instruction word on fetch, decodes its
// immediate into a 32-bit register and streams it out LSB-first, W bits per
// counted cycle. Also holds the rd/rs1/rs2 register addresses.
module serv_immdec_wide #(
   parameter int unsigned W          = 4,
   parameter int unsigned CSR_IMM_EN = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wb_en,
   input  logic [24:0]   i_wb_rdt,
   input  logic [2:0]    i_fmt,
   input  logic          i_cnt_en,
   output logic [W-1:0]  o_imm,
   output logic          o_imm_last,
   output logic          o_busy,
   output logic [4:0]    o_rd_addr,
   output logic [4:0]    o_rs1_addr,
   output logic [4:0]    o_rs2_addr
);

   localparam int unsigned N  = 32 / W;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [31:0]     r_imm;
   logic [31:0]     w_imm_dec;
   logic [KW-1:0]   r_k;
   logic            w_last;
   logic [4:0]      r_rd;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;

   // Instruction bits keep their architectural numbering [31:7]
   logic [31:7]     w_instr;
   assign w_instr = i_wb_rdt;

   assign w_last     = (r_k == KW'(N - 1));
   assign o_imm_last = w_last;
   assign o_busy     = (r_state == ST_BUSY);
   assign o_rd_addr  = r_rd;
   assign o_rs1_addr = r_rs1;
   assign o_rs2_addr = r_rs2;

   // Decode the full 32-bit immediate from the incoming fetch word
   always_comb begin
      w_imm_dec = '0;
      case (i_fmt)
         3'd0: w_imm_dec = {{20{w_instr[31]}}, w_instr[31:20]};
         3'd1: w_imm_dec = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         3'd2: w_imm_dec = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                            w_instr[30:25], w_instr[11:8], 1'b0};
         3'd3: w_imm_dec = {w_instr[31:12], 12'b0};
         3'd4: w_imm_dec = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                            w_instr[20], w_instr[30:21], 1'b0};
         3'd5: if (CSR_IMM_EN != 0) w_imm_dec = {27'b0, w_instr[19:15]};
         default: w_imm_dec = '0;
      endcase
   end

   // Select the current W-bit chunk; constant-indexed mux keeps selects static
   always_comb begin
      o_imm = '0;
      for (int unsigned c = 0; c < N; c++) begin
         if (r_k == KW'(c)) o_imm = r_imm[c*W +: W];
      end
   end

   // Busy state: set on load, cleared when the last chunk is consumed
   always_comb begin
      w_state_nxt = r_state;
      if (i_wb_en)
         w_state_nxt = ST_BUSY;
      else if (i_cnt_en && w_last)
         w_state_nxt = ST_IDLE;
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Chunk index: load restarts it; counting wraps and keeps replaying
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_k <= '0;
      else if (i_wb_en)
         r_k <= '0;
      else if (i_cnt_en)
         r_k <= w_last ? '0 : r_k + KW'(1);
   end

   // Immediate and register addresses are captured only on load
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_imm <= '0;
         r_rd  <= '0;
         r_rs1 <= '0;
         r_rs2 <= '0;
      end else if (i_wb_en) begin
         r_imm <= w_imm_dec;
         r_rd  <= w_instr[11:7];
         r_rs1 <= w_instr[19:15];
         r_rs2 <= w_instr[24:20];
      end
   end

endmodule
